// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the CPU data-port bridge: MMIO register offsets,
// CTRL bit positions and the access target selector.
package dmem_mmio_pkg;

    localparam logic [7:0] LED_OFS  = 8'h00;
    localparam logic [7:0] SW_OFS   = 8'h04;
    localparam logic [7:0] CNT_OFS  = 8'h08;
    localparam logic [7:0] CMP_OFS  = 8'h0C;
    localparam logic [7:0] CTRL_OFS = 8'h10;
    localparam logic [7:0] STAT_OFS = 8'h14;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    typedef enum logic [1:0] {SEL_RAM, SEL_MMIO, SEL_NONE} sel_t;

endpackage

// File: rtl/mmio_timer.sv
// Compare timer: free-running counter with compare, optional autoreload,
// sticky match flag (write-1-to-clear) and a level interrupt.
module mmio_timer
    import dmem_mmio_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_cnt,
    input  logic                 wr_cmp,
    input  logic                 wr_ctrl,
    input  logic                 wr_stat,
    input  logic [DATAWIDTH-1:0] wdata,
    output logic [DATAWIDTH-1:0] cnt,
    output logic [DATAWIDTH-1:0] cmp,
    output logic [2:0]           ctrl,
    output logic                 match,
    output logic                 irq
);

    logic hit;

    // A CPU write to CNT pre-empts both the count step and the match.
    assign hit = !wr_cnt && ctrl[CTRL_EN] && (cnt == cmp);
    assign irq = match && ctrl[CTRL_IE];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            cmp   <= '1;
            ctrl  <= '0;
            match <= 1'b0;
        end else begin
            if (wr_cmp)  cmp  <= wdata;
            if (wr_ctrl) ctrl <= wdata[2:0];
            if (wr_cnt)
                cnt <= wdata;
            else if (ctrl[CTRL_EN])
                cnt <= (hit && ctrl[CTRL_AR]) ? '0 : cnt + 1'b1;
            if (hit)
                match <= 1'b1;
            else if (wr_stat && wdata[0])
                match <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// CPU data-port bridge: decodes each access to word RAM or the MMIO page
// (LED, synchronised switches, compare timer). Reads are combinational.
module dmem_mmio_bridge
    import dmem_mmio_pkg::*;
#(
    parameter int                   DATAWIDTH = 32,
    parameter int                   ADDRWIDTH = 32,
    parameter int                   RAM_AW    = 8,
    parameter logic [ADDRWIDTH-1:0] MMIO_BASE = 32'h0000_7F00,
    parameter int                   IO_W      = 16
) (
    input  logic                 iCPU_Clk,
    input  logic                 iCPU_Reset,
    input  logic [ADDRWIDTH-1:0] iAB,
    input  logic                 iWR,
    input  logic [DATAWIDTH-1:0] iWriteData,
    output logic [DATAWIDTH-1:0] oReadData,
    input  logic [IO_W-1:0]      iSwitch,
    output logic [IO_W-1:0]      oLED,
    output logic                 oTimerIrq,
    output logic                 oBusError
);

    localparam logic [ADDRWIDTH-1:0] RAM_LIMIT = ADDRWIDTH'(64'd4 << RAM_AW);

    logic [DATAWIDTH-1:0] mem [2**RAM_AW];
    logic [RAM_AW-1:0]    ram_idx;
    logic [7:0]           ofs;
    sel_t                 sel;
    logic                 ofs_ok, wr_ok, ram_we, mmio_we;
    logic [IO_W-1:0]      led_q, sw_meta, sw_sync;
    logic [DATAWIDTH-1:0] t_cnt, t_cmp;
    logic [2:0]           t_ctrl;
    logic                 t_match;

    assign ram_idx = iAB[RAM_AW+1:2];
    assign ofs     = iAB[7:0];
    assign oLED    = led_q;

    always_comb begin
        sel = SEL_NONE;
        if (iAB < RAM_LIMIT)
            sel = SEL_RAM;
        else if (iAB[ADDRWIDTH-1:8] == MMIO_BASE[ADDRWIDTH-1:8])
            sel = SEL_MMIO;
        ofs_ok    = ofs inside {LED_OFS, SW_OFS, CNT_OFS, CMP_OFS, CTRL_OFS, STAT_OFS};
        oBusError = (iAB[1:0] != 2'b00) || (sel == SEL_NONE) || (sel == SEL_MMIO && !ofs_ok);
    end

    // Writes during reset are dropped, including RAM writes.
    assign wr_ok   = iWR && !oBusError && !iCPU_Reset;
    assign ram_we  = wr_ok && (sel == SEL_RAM);
    assign mmio_we = wr_ok && (sel == SEL_MMIO);

    always_ff @(posedge iCPU_Clk) begin
        if (ram_we) mem[ram_idx] <= iWriteData;
    end

    always_ff @(posedge iCPU_Clk) begin
        if (iCPU_Reset) begin
            led_q   <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= iSwitch;
            sw_sync <= sw_meta;
            if (mmio_we && ofs == LED_OFS) led_q <= iWriteData[IO_W-1:0];
        end
    end

    mmio_timer #(.DATAWIDTH(DATAWIDTH)) u_timer (
        .clk     (iCPU_Clk),
        .rst     (iCPU_Reset),
        .wr_cnt  (mmio_we && ofs == CNT_OFS),
        .wr_cmp  (mmio_we && ofs == CMP_OFS),
        .wr_ctrl (mmio_we && ofs == CTRL_OFS),
        .wr_stat (mmio_we && ofs == STAT_OFS),
        .wdata   (iWriteData),
        .cnt     (t_cnt),
        .cmp     (t_cmp),
        .ctrl    (t_ctrl),
        .match   (t_match),
        .irq     (oTimerIrq)
    );

    always_comb begin
        oReadData = '0;
        if (!oBusError) begin
            case (sel)
                SEL_RAM:  oReadData = mem[ram_idx];
                SEL_MMIO: begin
                    case (ofs)
                        LED_OFS:  oReadData = DATAWIDTH'(led_q);
                        SW_OFS:   oReadData = DATAWIDTH'(sw_sync);
                        CNT_OFS:  oReadData = t_cnt;
                        CMP_OFS:  oReadData = t_cmp;
                        CTRL_OFS: oReadData = DATAWIDTH'(t_ctrl);
                        STAT_OFS: oReadData = DATAWIDTH'(t_match);
                        default:  oReadData = '0;
                    endcase
                end
                default:  oReadData = '0;
            endcase
        end
    end

endmodule
